// File: rtl/vga_mem_arbiter.sv
// Frame-buffer port arbiter: display burst reads (priority) vs. single-word writes, with a read-streak limit.
// Optional ARB_STATS_EN adds burst/write counters with a synchronous clear.
module vga_mem_arbiter #(
    parameter int ADDR_W        = 25,
    parameter int DATA_W        = 32,
    parameter int BURST_LEN     = 8,
    parameter int BURST_W       = 4,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic               clock_50,
    input  logic               reset_n,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_grant,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               rd_done,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic               busy,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_read,
    output logic               mem_write,
    output logic [DATA_W-1:0]  mem_writedata,
    output logic [BURST_W-1:0] mem_burstcount,
    input  logic               mem_waitrequest,
    input  logic [DATA_W-1:0]  mem_readdata,
    input  logic               mem_readdatavalid
`ifdef ARB_STATS_EN
    ,
    input  logic               stat_clear,
    output logic [31:0]        stat_rd_bursts,
    output logic [31:0]        stat_wr_words
`endif
);

    localparam int BEAT_W   = $clog2(BURST_LEN + 1);
    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_t;

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic                wr_pending;
    logic                rd_wins;

    // A write still asserting wr_req during its own ack cycle is the finished request, not a new one.
    assign wr_pending = wr_req && !wr_ack;
    assign rd_wins    = rd_req && (!wr_pending || (streak_reg < STREAK_W'(MAX_RD_STREAK)));
    assign busy       = (state_reg != IDLE);

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            beat_reg       <= '0;
            streak_reg     <= '0;
            rd_grant       <= 1'b0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            rd_done        <= 1'b0;
            wr_ack         <= 1'b0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_burstcount <= '0;
        end else begin
            rd_grant <= 1'b0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            wr_ack   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rd_wins) begin
                        mem_address    <= rd_addr;
                        mem_read       <= 1'b1;
                        mem_burstcount <= BURST_W'(BURST_LEN);
                        state_reg      <= RD_CMD;
                    end else if (wr_pending) begin
                        mem_address    <= wr_addr;
                        mem_writedata  <= wr_data;
                        mem_write      <= 1'b1;
                        mem_burstcount <= BURST_W'(1);
                        state_reg      <= WR_CMD;
                    end
                end
                RD_CMD: begin
                    if (!mem_waitrequest) begin
                        mem_read  <= 1'b0;
                        rd_grant  <= 1'b1;
                        beat_reg  <= '0;
                        state_reg <= RD_DATA;
                        if (streak_reg < STREAK_W'(MAX_RD_STREAK))
                            streak_reg <= streak_reg + STREAK_W'(1);
                    end
                end
                RD_DATA: begin
                    if (mem_readdatavalid) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem_readdata;
                        beat_reg <= beat_reg + BEAT_W'(1);
                        if (beat_reg == BEAT_W'(BURST_LEN - 1)) begin
                            rd_done   <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                WR_CMD: begin
                    if (!mem_waitrequest) begin
                        mem_write  <= 1'b0;
                        wr_ack     <= 1'b1;
                        streak_reg <= '0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd_bursts <= '0;
            stat_wr_words  <= '0;
        end else if (stat_clear) begin
            stat_rd_bursts <= '0;
            stat_wr_words  <= '0;
        end else begin
            if (rd_done) stat_rd_bursts <= stat_rd_bursts + 32'd1;
            if (wr_ack)  stat_wr_words  <= stat_wr_words + 32'd1;
        end
    end
`endif

endmodule
